// File: rtl/reset_sequencer.sv
// Releases N_STAGES reset domains in index order, each after DELAY settle cycles and an Ack from the previous stage.
// Button requests pass through a SYNC_STAGES synchroniser; a missing Ack within TIMEOUT cycles re-asserts all resets and flags Fault.
module reset_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int DELAY       = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2,
    localparam int SW         = (N_STAGES > 2) ? $clog2(N_STAGES) : 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                BTNS,
    input  logic [N_STAGES-1:0] Ack,
    output logic [N_STAGES-1:0] Reset_out,
    output logic [SW-1:0]       Stage,
    output logic                Done,
    output logic                Fault
);
    localparam int MAXC = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DLY_LAST   = CW'(DELAY - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGES - 1);

    typedef enum logic [2:0] {HOLD, DLY, WACK, RUN, FLT} state_t;

    state_t                state_q, state_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  req_s;
    logic [N_STAGES-1:0]   rst_nxt;
    logic [SW-1:0]         stage_nxt;
    logic                  done_nxt, fault_nxt;
    logic                  dly_end, ack_hit, to_end, last_stage;

    assign req_s      = sync_q[SYNC_STAGES-1];
    assign dly_end    = (cnt_q == DLY_LAST);
    assign to_end     = (cnt_q == TO_LAST);
    assign ack_hit    = Ack[Stage];
    assign last_stage = (Stage == STAGE_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q    <= '0;
            state_q   <= HOLD;
            cnt_q     <= '0;
            Reset_out <= '1;
            Stage     <= '0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], BTNS};
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            Reset_out <= rst_nxt;
            Stage     <= stage_nxt;
            Done      <= done_nxt;
            Fault     <= fault_nxt;
        end
    end

    // Counter is cleared on every state change so it never needs to wrap.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        if (req_s) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_nxt = DLY;
                    cnt_nxt   = '0;
                end
                DLY: begin
                    if (dly_end) begin
                        state_nxt = WACK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
                WACK: begin
                    if (ack_hit) begin
                        state_nxt = last_stage ? RUN : DLY;
                        cnt_nxt   = '0;
                    end else if (to_end) begin
                        state_nxt = FLT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    // Registered outputs; Ack on the timeout cycle takes precedence over the fault.
    always_comb begin
        rst_nxt   = Reset_out;
        stage_nxt = Stage;
        done_nxt  = Done;
        fault_nxt = Fault;
        if (req_s) begin
            rst_nxt   = '1;
            stage_nxt = '0;
            done_nxt  = 1'b0;
            fault_nxt = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    rst_nxt   = '1;
                    stage_nxt = '0;
                end
                DLY: begin
                    if (dly_end) rst_nxt[Stage] = 1'b0;
                end
                WACK: begin
                    if (ack_hit) begin
                        if (last_stage) done_nxt = 1'b1;
                        else            stage_nxt = Stage + SW'(1);
                    end else if (to_end) begin
                        rst_nxt   = '1;
                        fault_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed checks of release timing, timeout, abort, async reset and glitch rejection for reset_sequencer.
module tb_reset_sequencer;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       BTNS;
    logic [3:0] Ack;
    logic [3:0] Reset_out;
    logic [1:0] Stage;
    logic       Done;
    logic       Fault;

    int n_cmp = 0;
    int n_bad = 0;

    reset_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .BTNS      (BTNS),
        .Ack       (Ack),
        .Reset_out (Reset_out),
        .Stage     (Stage),
        .Done      (Done),
        .Fault     (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold BTNS long enough to fill the synchroniser, then release at a negedge.
    // Edge numbering below counts the first edge that samples BTNS=0 as edge 1.
    task automatic request();
        BTNS = 1'b1;
        step(4);
        BTNS = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        BTNS    = 1'b0;
        Ack     = 4'hF;
        step(1);
        chk("rst_reset_out", 32'(Reset_out), 32'hF);
        chk("rst_stage",     32'(Stage),     32'h0);
        chk("rst_done",      32'(Done),      32'h0);
        chk("rst_fault",     32'(Fault),     32'h0);
        step(1);
        Reset_n = 1'b1;
        step(3);

        // Nominal sequence with Ack tied high.
        request();
        step(10);
        chk("nom_pre_rel0",  32'(Reset_out), 32'hF);
        step(1);
        chk("nom_rel0",      32'(Reset_out), 32'hE);
        step(8);
        chk("nom_pre_rel1",  32'(Reset_out), 32'hE);
        step(1);
        chk("nom_rel1",      32'(Reset_out), 32'hC);
        chk("nom_stage1",    32'(Stage),     32'h1);
        step(9);
        chk("nom_rel2",      32'(Reset_out), 32'h8);
        step(9);
        chk("nom_rel3",      32'(Reset_out), 32'h0);
        chk("nom_done_pre",  32'(Done),      32'h0);
        step(1);
        chk("nom_done",      32'(Done),      32'h1);
        chk("nom_stage3",    32'(Stage),     32'h3);

        // Ack dropping in RUN is ignored.
        Ack = 4'h0;
        step(5);
        chk("run_ack_drop_done", 32'(Done),      32'h1);
        chk("run_ack_drop_rst",  32'(Reset_out), 32'h0);

        // Short BTNS glitch between edges is never sampled.
        #1 BTNS = 1'b1;
        #3 BTNS = 1'b0;
        step(6);
        chk("glitch_done", 32'(Done),      32'h1);
        chk("glitch_rst",  32'(Reset_out), 32'h0);

        // Async reset while in RUN.
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_run_rst",  32'(Reset_out), 32'hF);
        chk("arst_run_done", 32'(Done),      32'h0);
        chk("arst_run_stg",  32'(Stage),     32'h0);
        step(1);
        Reset_n = 1'b1;

        // Ack[2] never comes: fault exactly 255 cycles after stage 2 release.
        Ack = 4'b1011;
        request();
        step(29);
        chk("to_rel2",       32'(Reset_out), 32'h8);
        chk("to_stage2",     32'(Stage),     32'h2);
        step(254);
        chk("to_pre_fault",  32'(Fault),     32'h0);
        chk("to_pre_rst",    32'(Reset_out), 32'h8);
        step(1);
        chk("to_fault",      32'(Fault),     32'h1);
        chk("to_fault_rst",  32'(Reset_out), 32'hF);
        chk("to_fault_stg",  32'(Stage),     32'h2);
        Ack = 4'hF;
        step(20);
        chk("to_sticky",     32'(Fault),     32'h1);
        chk("to_sticky_rst", 32'(Reset_out), 32'hF);

        // Ack[1] arrives on the timeout cycle: Ack wins.
        Ack = 4'b1101;
        request();
        chk("ackwin_clr_flt", 32'(Fault), 32'h0);
        step(274);
        chk("ackwin_pre",    32'(Reset_out), 32'hC);
        chk("ackwin_noflt0", 32'(Fault),     32'h0);
        Ack = 4'hF;
        step(1);
        chk("ackwin_noflt1", 32'(Fault),     32'h0);
        chk("ackwin_stage2", 32'(Stage),     32'h2);
        step(19);
        chk("ackwin_done",   32'(Done),      32'h1);
        chk("ackwin_rst",    32'(Reset_out), 32'h0);
        chk("ackwin_fault",  32'(Fault),     32'h0);

        // Abort while stage 2 is in its settle delay.
        request();
        step(23);
        BTNS = 1'b1;
        step(2);
        chk("abort_pre_rst", 32'(Reset_out), 32'hC);
        chk("abort_pre_stg", 32'(Stage),     32'h2);
        step(1);
        chk("abort_rst",     32'(Reset_out), 32'hF);
        chk("abort_stage",   32'(Stage),     32'h0);
        chk("abort_done",    32'(Done),      32'h0);
        step(1);
        BTNS = 1'b0;
        step(11);
        chk("reseq_rel0",    32'(Reset_out), 32'hE);
        step(28);
        chk("reseq_done",    32'(Done),      32'h1);
        chk("reseq_rst",     32'(Reset_out), 32'h0);

        // Unreleased stages' Ack bits are ignored while stage 0 waits.
        Ack = 4'b1110;
        request();
        step(11);
        chk("unrel_rel0",    32'(Reset_out), 32'hE);
        step(5);
        chk("unrel_stage0",  32'(Stage),     32'h0);
        chk("unrel_rst",     32'(Reset_out), 32'hE);
        Ack = 4'b0001;
        step(1);
        chk("unrel_stage1",  32'(Stage),     32'h1);
        Ack = 4'hF;
        step(27);
        chk("unrel_done",    32'(Done),      32'h1);

        // Async reset mid-sequence.
        request();
        step(15);
        chk("arst_mid_pre",  32'(Reset_out), 32'hE);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_mid_rst",  32'(Reset_out), 32'hF);
        chk("arst_mid_stg",  32'(Stage),     32'h0);
        chk("arst_mid_done", 32'(Done),      32'h0);
        step(1);
        Reset_n = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
